// File: rtl/pdm_tx_modulator.sv
// -----------------------------------------------------------------------------
// pdm_tx_modulator
//
// First-order delta-sigma modulator. It converts signed PCM samples into a
// 1-bit PDM stream. The stream drives loopback/self-test stimulus into a PDM
// receive channel, or a transducer pin.
//
// Samples arrive on a valid/ready push port and wait in a small FIFO. One
// sample is consumed on each ce_pcm strobe, and one PDM bit is produced on
// each ce_pdm strobe. Both strobes come from the shared clock-enable
// generators and are one wb_clk_i cycle wide.
//
// Ports:
//   wb_clk_i         in   system clock, rising edge
//   wb_rst_i         in   synchronous active-high reset
//   enable_i         in   modulator run enable (0 = idle, output forced low)
//   ce_pdm           in   one PDM bit step
//   ce_pcm           in   consume the next PCM sample
//   s_valid_i        in   push request
//   s_data_i         in   PCM sample, signed two's complement, DW bits
//   s_ready_o        out  FIFO can accept a sample
//   pdm_o            out  registered PDM bitstream
//   fifo_level_o     out  number of samples currently stored
//   underflow_o      out  sticky: ce_pcm arrived with an empty FIFO
//   clr_underflow_i  in   clears underflow_o (a new underflow wins)
// -----------------------------------------------------------------------------
module pdm_tx_modulator #(
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          enable_i,
  input  logic                          ce_pdm,
  input  logic                          ce_pcm,
  input  logic                          s_valid_i,
  input  logic [DW-1:0]                 s_data_i,
  output logic                          s_ready_o,
  output logic                          pdm_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          underflow_o,
  input  logic                          clr_underflow_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;

  logic push_fire;
  logic pcm_step;
  logic pop_fire;
  logic pdm_step;
  logic fifo_empty;

  assign fifo_empty = (level_reg == '0);

  // Ready depends only on the registered level. A pop in the same cycle
  // does not open a slot for a push into a full FIFO, so the push retries.
  assign s_ready_o = (level_reg != LEVEL_FULL);
  assign push_fire = s_valid_i && s_ready_o;

  // Both strobes are ignored while the modulator is disabled.
  assign pcm_step  = enable_i && ce_pcm;
  assign pdm_step  = enable_i && ce_pdm;
  assign pop_fire  = pcm_step && !fifo_empty;

  // Storage has no reset. Contents become invalid when the pointers and
  // level are cleared.
  always_ff @(posedge wb_clk_i) begin
    if (push_fire) begin
      mem[wr_ptr_reg] <= s_data_i;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two. The level
  // cannot leave 0..FIFO_DEPTH because push and pop are both guarded.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_fire, pop_fire})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign fifo_level_o = level_reg;

  // ---------------------------------------------------------------------------
  // Current sample (registered FIFO read)
  // ---------------------------------------------------------------------------
  // On an empty pop the previous sample is held. A push in the same cycle
  // only lands in the FIFO and is not forwarded here.
  logic [DW-1:0] cur_sample_reg;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cur_sample_reg <= '0;
    end else if (!enable_i) begin
      cur_sample_reg <= '0;
    end else if (pop_fire) begin
      cur_sample_reg <= mem[rd_ptr_reg];
    end
  end

  // ---------------------------------------------------------------------------
  // First-order delta-sigma step
  // ---------------------------------------------------------------------------
  // Inverting the MSB turns two's complement into offset binary. The
  // accumulator carry-out is then the output bit, and the ones density is
  // exactly u / 2^DW. The step reads cur_sample_reg before this edge, so a
  // sample loaded by a coincident ce_pcm applies from the next ce_pdm.
  logic [DW-1:0] offset_sample;
  logic [DW-1:0] acc_reg;
  logic [DW:0]   sum_next;
  logic          pdm_reg;

  assign offset_sample = {~cur_sample_reg[DW-1], cur_sample_reg[DW-2:0]};
  assign sum_next      = {1'b0, acc_reg} + {1'b0, offset_sample};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      acc_reg <= '0;
      pdm_reg <= 1'b0;
    end else if (!enable_i) begin
      acc_reg <= '0;
      pdm_reg <= 1'b0;
    end else if (pdm_step) begin
      acc_reg <= sum_next[DW-1:0];
      pdm_reg <= sum_next[DW];
    end
  end

  assign pdm_o = pdm_reg;

  // ---------------------------------------------------------------------------
  // Sticky underflow flag
  // ---------------------------------------------------------------------------
  logic underflow_reg;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      underflow_reg <= 1'b0;
    end else if (pcm_step && fifo_empty) begin
      underflow_reg <= 1'b1;   // a fresh underflow beats a coincident clear
    end else if (clr_underflow_i) begin
      underflow_reg <= 1'b0;
    end
  end

  assign underflow_o = underflow_reg;

endmodule

// File: tb/tb_pdm_tx_modulator.sv
// -----------------------------------------------------------------------------
// tb_pdm_tx_modulator
//
// Bench for pdm_tx_modulator. The driver issues directed vectors. For every
// enabled ce_pdm strobe it queues the hand-computed PDM bit, and a monitor
// pops that bit and compares it one step after the edge. FIFO level, ready
// and underflow are checked inline by the driver.
// -----------------------------------------------------------------------------
module tb_pdm_tx_modulator;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        ce_pdm;
  logic        ce_pcm;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        pdm;
  logic [2:0]  level;
  logic        underflow;
  logic        clr_uf;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  pdm_tx_modulator #(.DW(16), .FIFO_DEPTH(4)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .enable_i        (enable),
    .ce_pdm          (ce_pdm),
    .ce_pcm          (ce_pcm),
    .s_valid_i       (s_valid),
    .s_data_i        (s_data),
    .s_ready_o       (s_ready),
    .pdm_o           (pdm),
    .fifo_level_o    (level),
    .underflow_o     (underflow),
    .clr_underflow_i (clr_uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pdm_o updates on the edge that samples an enabled ce_pdm.
  always @(posedge clk) begin
    if (!rst && enable && ce_pdm) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pdm_unexpected_step actual=%0b required=no step", pdm);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (pdm !== e) begin
          failures++;
          $display("FAIL pdm_bit actual=%0b required=%0b", pdm, e);
        end else begin
          $display("pdm step bit=%0b ok", pdm);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("check %s value=%0h ok", name, act);
    end
  endtask

  // All driver tasks start and end right after a falling edge.
  task automatic step(input bit pcm, input bit pdm_s, input bit expb);
    ce_pcm = pcm;
    ce_pdm = pdm_s;
    if (pdm_s && enable) exp_q.push_back(expb);
    @(negedge clk);
    ce_pcm = 1'b0;
    ce_pdm = 1'b0;
  endtask

  // Issue n ce_pdm strobes; expected bits are given MSB-first in 'bits'.
  task automatic run_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, bits[n-1-i]);
  endtask

  task automatic push(input logic [15:0] v);
    chk("push_ready", int'(s_ready), 1);
    s_valid = 1'b1;
    s_data  = v;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // One disabled cycle clears acc and cur_sample without touching the FIFO.
  task automatic restart();
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; ce_pdm = 1'b0; ce_pcm = 1'b0;
    s_valid = 1'b0; s_data = '0; clr_uf = 1'b0;

    // Reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_pdm", int'(pdm), 0);
    chk("rst_ready", int'(s_ready), 1);
    chk("rst_level", int'(level), 0);
    chk("rst_underflow", int'(underflow), 0);
    rst = 1'b0;
    @(negedge clk);

    // Midscale tone
    enable = 1'b1;
    push(16'h0000);
    chk("mid_level_after_push", int'(level), 1);
    step(1'b1, 1'b0, 1'b0);
    chk("mid_level_after_pop", int'(level), 0);
    run_bits(16'b0101_0101, 8);

    // 3/4 density
    restart();
    push(16'h4000);
    step(1'b1, 1'b0, 1'b0);
    run_bits(16'b0111_0111, 8);

    // Rails
    restart();
    push(16'h8000);
    step(1'b1, 1'b0, 1'b0);
    run_bits(16'h0000, 16);
    restart();
    push(16'h7FFF);
    step(1'b1, 1'b0, 1'b0);
    run_bits(16'h7FFF, 16);

    // FIFO full / back-pressure. The values give distinct bit patterns,
    // so the pop order shows up in the PDM stream.
    restart();
    push(16'h8000);
    push(16'h7FFF);
    push(16'h4000);
    push(16'h0000);
    chk("full_level", int'(level), 4);
    chk("full_ready", int'(s_ready), 0);
    s_valid = 1'b1;
    s_data  = 16'hC000;
    @(negedge clk);
    @(negedge clk);
    chk("full_hold_level", int'(level), 4);
    step(1'b1, 1'b0, 1'b0);          // pop while full: the push is not taken
    chk("full_pop_level", int'(level), 3);
    chk("full_pop_ready", int'(s_ready), 1);
    @(negedge clk);                  // held push is accepted now
    s_valid = 1'b0;
    chk("full_retry_level", int'(level), 4);
    run_bits(16'b0000_0000, 8);      // 0x8000
    restart(); step(1'b1, 1'b0, 1'b0); run_bits(16'b0111_1111, 8); // 0x7FFF
    restart(); step(1'b1, 1'b0, 1'b0); run_bits(16'b0111_0111, 8); // 0x4000
    restart(); step(1'b1, 1'b0, 1'b0); run_bits(16'b0101_0101, 8); // 0x0000
    restart(); step(1'b1, 1'b0, 1'b0); run_bits(16'b0001_0001, 8); // 0xC000
    chk("drain_level", int'(level), 0);

    // Underflow. cur_sample stays 0xC000, so the bits keep repeating 0,0,0,1.
    step(1'b1, 1'b0, 1'b0);
    chk("uf_set", int'(underflow), 1);
    run_bits(16'b0001, 4);
    clr_uf = 1'b1;
    @(negedge clk);
    clr_uf = 1'b0;
    chk("uf_clear", int'(underflow), 0);
    s_valid = 1'b1;                  // push coincident with an empty pop
    s_data  = 16'h8000;
    clr_uf  = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    s_valid = 1'b0;
    clr_uf  = 1'b0;
    chk("uf_set_beats_clr", int'(underflow), 1);
    chk("uf_push_stored", int'(level), 1);
    run_bits(16'b0001, 4);           // still 0xC000: no bypass
    enable = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    chk("dis_pdm_low", int'(pdm), 0);
    chk("dis_no_pop", int'(level), 1);
    chk("dis_uf_kept", int'(underflow), 1);
    enable = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    chk("en_pop_level", int'(level), 0);
    clr_uf = 1'b1;
    @(negedge clk);
    clr_uf = 1'b0;
    enable = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    chk("dis_no_underflow", int'(underflow), 0);

    // Coincident ce_pcm and ce_pdm: the step still uses the old sample.
    restart();
    push(16'h8000);
    push(16'h7FFF);
    step(1'b1, 1'b0, 1'b0);          // cur = 0x8000
    step(1'b1, 1'b1, 1'b0);          // step with 0x8000, load 0x7FFF
    run_bits(16'b011, 3);

    // Reset mid-stream
    step(1'b1, 1'b0, 1'b0);
    chk("pre_rst_uf", int'(underflow), 1);
    restart();
    push(16'h4000);
    push(16'h1234);
    step(1'b1, 1'b0, 1'b0);
    run_bits(16'b0111, 4);
    chk("pre_rst_pdm", int'(pdm), 1);
    chk("pre_rst_level", int'(level), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pdm", int'(pdm), 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_ready", int'(s_ready), 1);
    chk("mid_rst_uf", int'(underflow), 0);
    rst = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
